// File: rtl/muldiv_unit.sv
// muldiv_unit: shared iterative multiply/divide engine for the HI/LO registers.
// One bit per cycle: shift-add for MULT/MULTU, restoring division for DIV/DIVU,
// both on operand magnitudes with the result sign applied in a final FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_ZERO = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_nx;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nx;

    // Latched operation context
    logic              is_div_q;
    logic              neg_lo_q;   // negate product (MULT) or quotient (DIV)
    logic              neg_hi_q;   // negate remainder (DIV with negative dividend)
    logic [WIDTH-1:0]  b_mag_q;    // multiplicand or divisor magnitude
    logic [W2-1:0]     acc_q;      // {partial product / remainder, multiplier / quotient}
    logic [W2-1:0]     acc_nx;

    // Input decode (only meaningful in the accepting cycle)
    logic              signed_op_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic [WIDTH-1:0]  a_mag_c;
    logic [WIDTH-1:0]  b_mag_c;
    logic              div_by_zero_c;
    logic              can_accept_c;
    logic              accept_c;

    // Iteration and fix-up datapath
    logic [WIDTH:0]    mul_sum_c;
    logic [WIDTH:0]    div_trial_c;
    logic [WIDTH:0]    div_diff_c;
    logic              div_ge_c;
    logic [W2-1:0]     prod_fix_c;
    logic [WIDTH-1:0]  quot_fix_c;
    logic [WIDTH-1:0]  rem_fix_c;
    logic [WIDTH-1:0]  hi_fix_c;
    logic [WIDTH-1:0]  lo_fix_c;

    // Operand magnitudes and sign bookkeeping; -2^(W-1) maps to itself as unsigned
    always_comb begin
        signed_op_c   = ~op[0];
        a_neg_c       = signed_op_c & a_in[WIDTH-1];
        b_neg_c       = signed_op_c & b_in[WIDTH-1];
        a_mag_c       = a_neg_c ? (WIDTH'(0) - a_in) : a_in;
        b_mag_c       = b_neg_c ? (WIDTH'(0) - b_in) : b_in;
        div_by_zero_c = op[1] & (b_in == WIDTH'(0));
        can_accept_c  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ZERO);
        accept_c      = start & can_accept_c;
    end

    // Next-state and iteration counter
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ZERO: begin
                state_nx = S_IDLE;
                if (start) begin
                    if (div_by_zero_c) begin
                        state_nx = S_ZERO;
                        cnt_nx   = CW'(0);
                    end else begin
                        state_nx = S_RUN;
                        cnt_nx   = CW'(WIDTH);
                    end
                end
            end
            S_RUN: begin
                cnt_nx = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = CW'(0);
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CW'(0);
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // One iteration step: shift-add or restoring-divide on the accumulator
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : (WIDTH+1)'(0));
        div_trial_c = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_ge_c    = (div_trial_c >= {1'b0, b_mag_q});
        div_diff_c  = div_trial_c - {1'b0, b_mag_q};
        acc_nx      = acc_q;
        if (is_div_q) begin
            if (div_ge_c) begin
                acc_nx = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = {div_trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = {mul_sum_c, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the final accumulator
    always_comb begin
        prod_fix_c = neg_lo_q ? (W2'(0) - acc_q) : acc_q;
        quot_fix_c = neg_lo_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix_c  = neg_hi_q ? (WIDTH'(0) - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
        hi_fix_c   = is_div_q ? rem_fix_c  : prod_fix_c[W2-1:WIDTH];
        lo_fix_c   = is_div_q ? quot_fix_c : prod_fix_c[WIDTH-1:0];
    end

    // Operation context capture and accumulator iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_mag_q  <= WIDTH'(0);
            acc_q    <= W2'(0);
        end else if (accept_c && !div_by_zero_c) begin
            is_div_q <= op[1];
            neg_lo_q <= a_neg_c ^ b_neg_c;
            neg_hi_q <= op[1] & a_neg_c;
            b_mag_q  <= b_mag_c;
            acc_q    <= {WIDTH'(0), a_mag_c};
        end else if (state_q == S_RUN) begin
            acc_q    <= acc_nx;
        end
    end

    // Registered handshake outputs, decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            busy    <= (state_nx == S_RUN) || (state_nx == S_FIX);
            done    <= (state_nx == S_DONE) || (state_nx == S_ZERO);
            divzero <= (state_nx == S_ZERO);
        end
    end

    // HI/LO result registers, written only at the end of FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out <= WIDTH'(0);
            lo_out <= WIDTH'(0);
        end else if (state_q == S_FIX) begin
            hi_out <= hi_fix_c;
            lo_out <= lo_fix_c;
        end
    end

endmodule
